// File: rtl/dep_pkg.sv
// rtl/dep_pkg.sv - shared widths, tag/address types and the tracker entry record
package dep_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int ID_W   = 3;

    function automatic int depth_of(input int id_size);
        return 1 << id_size;
    endfunction

    localparam int DEPTH = depth_of(ID_W);

    typedef logic [ID_W-1:0]   tag_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [REG_W-1:0]  value_t;

    typedef struct packed {
        logic   valid;
        logic   done;
        addr_t  addr;
        value_t value;
    } entry_t;

endpackage

// File: rtl/dep_lookup.sv
// rtl/dep_lookup.sv - youngest-match search of one register address over the live window
module dep_lookup
    import dep_pkg::*;
#(
    parameter int REGISTER_SIZE    = REG_W,
    parameter int REG_ADDRESS_SIZE = ADDR_W,
    parameter int ID_SIZE          = ID_W
) (
    input  entry_t                      i_entries [2**ID_SIZE],
    input  logic [ID_SIZE-1:0]          i_head,
    input  logic [REG_ADDRESS_SIZE-1:0] i_rd_addr,
    output logic                        o_hit,
    output logic [ID_SIZE-1:0]          o_id,
    output logic                        o_done,
    output logic [REGISTER_SIZE-1:0]    o_value
);

    localparam int DEPTH_L = depth_of(ID_SIZE);

    logic [ID_SIZE-1:0] w_idx;

    // Walk oldest to youngest from head; a later hit overrides, so the youngest wins.
    always_comb begin
        o_hit   = 1'b0;
        o_id    = '0;
        o_done  = 1'b0;
        o_value = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH_L; k++) begin
            w_idx = i_head + k[ID_SIZE-1:0];
            if (i_entries[w_idx].valid && (i_entries[w_idx].addr == i_rd_addr)
                && (i_rd_addr != '0)) begin
                o_hit   = 1'b1;
                o_id    = w_idx;
                o_done  = i_entries[w_idx].done;
                o_value = i_entries[w_idx].done ? i_entries[w_idx].value : '0;
            end
        end
    end

endmodule

// File: rtl/dep_tracker.sv
// rtl/dep_tracker.sv - in-order register dependency tracker; DEP_TRACKER_BYPASS_EN forwards same-cycle writebacks
module dep_tracker
    import dep_pkg::*;
#(
    parameter int REGISTER_SIZE    = REG_W,
    parameter int REG_ADDRESS_SIZE = ADDR_W,
    parameter int ID_SIZE          = ID_W,
    parameter int N_READ           = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     alloc_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]              alloc_addr,
    output logic                                     alloc_ready,
    output logic [ID_SIZE-1:0]                       alloc_id,
    input  logic                                     wb_valid,
    input  logic [ID_SIZE-1:0]                       wb_id,
    input  logic [REGISTER_SIZE-1:0]                 wb_value,
    input  logic                                     commit_valid,
    output logic                                     commit_ready,
    output logic [REG_ADDRESS_SIZE-1:0]              commit_addr,
    output logic [REGISTER_SIZE-1:0]                 commit_value,
    input  logic                                     flush,
    input  logic [N_READ-1:0][REG_ADDRESS_SIZE-1:0]  rd_addr,
    output logic [N_READ-1:0]                        dependency,
    output logic [N_READ-1:0]                        resolved,
    output logic [N_READ-1:0][REGISTER_SIZE-1:0]     value,
    output logic [N_READ-1:0][ID_SIZE-1:0]           rd_id
);

    localparam int DEPTH_L = depth_of(ID_SIZE);

    entry_t               r_entries [DEPTH_L];
    logic [ID_SIZE-1:0]   r_head;
    logic [ID_SIZE-1:0]   r_tail;
    logic [ID_SIZE:0]     r_count;

    entry_t               w_head_entry;
    logic                 w_alloc;
    logic                 w_commit;

    logic [N_READ-1:0]                    w_hit;
    logic [N_READ-1:0]                    w_done;
    logic [N_READ-1:0][ID_SIZE-1:0]       w_id;
    logic [N_READ-1:0][REGISTER_SIZE-1:0] w_val;

    assign w_head_entry = r_entries[r_head];
    assign alloc_ready  = (r_count != (ID_SIZE+1)'(DEPTH_L));
    assign alloc_id     = r_tail;
    assign commit_ready = w_head_entry.valid & w_head_entry.done;
    assign commit_addr  = w_head_entry.addr;
    assign commit_value = w_head_entry.value;
    assign w_alloc      = alloc_valid & alloc_ready;
    assign w_commit     = commit_valid & commit_ready;

    // Update order matters: a commit of the written-back head clears it last.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH_L; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (wb_valid && r_entries[wb_id].valid) begin
                r_entries[wb_id].done  <= 1'b1;
                r_entries[wb_id].value <= wb_value;
            end
            if (w_commit) begin
                r_entries[r_head] <= '0;
                r_head            <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_entries[r_tail] <= '{valid: 1'b1, done: 1'b0, addr: alloc_addr, value: '0};
                r_tail            <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar p = 0; p < N_READ; p++) begin : g_lookup
        dep_lookup #(
            .REGISTER_SIZE    (REGISTER_SIZE),
            .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE),
            .ID_SIZE          (ID_SIZE)
        ) u_lookup (
            .i_entries (r_entries),
            .i_head    (r_head),
            .i_rd_addr (rd_addr[p]),
            .o_hit     (w_hit[p]),
            .o_id      (w_id[p]),
            .o_done    (w_done[p]),
            .o_value   (w_val[p])
        );
    end

    always_comb begin
        dependency = w_hit;
        rd_id      = w_id;
        resolved   = w_done;
        value      = w_val;
`ifdef DEP_TRACKER_BYPASS_EN
        for (int p = 0; p < N_READ; p++) begin
            if (w_hit[p] && wb_valid && (wb_id == w_id[p])) begin
                resolved[p] = 1'b1;
                value[p]    = wb_value;
            end
        end
`endif
    end

endmodule

// File: doc/dep_tracker.md
DEP_TRACKER -- requirements
Module: dep_tracker

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, data width of a register value.
REQ-002 SHALL have parameter REG_ADDRESS_SIZE, default 5, architectural register address width.
REQ-003 SHALL have parameter ID_SIZE, default 3, entry tag width; depth DEPTH = 2**ID_SIZE.
REQ-004 SHALL have parameter N_READ, default 2, number of independent lookup ports.
REQ-005 SHALL have one clock and a synchronous, active-high reset: port clk (in, 1, rising-edge clock) and port reset (in, 1, synchronous active-high reset).
REQ-006 SHALL have ports alloc_valid (in, 1, allocate request), alloc_addr (in, REG_ADDRESS_SIZE, destination register), alloc_ready (out, 1, slot free) and alloc_id (out, ID_SIZE, tag granted = tail).
REQ-007 SHALL have ports wb_valid (in, 1), wb_id (in, ID_SIZE) and wb_value (in, REGISTER_SIZE); these mark an entry resolved.
REQ-008 SHALL have ports commit_valid (in, 1, retire head), commit_ready (out, 1, head valid and resolved), commit_addr (out, REG_ADDRESS_SIZE) and commit_value (out, REGISTER_SIZE).
REQ-009 SHALL have port flush (in, 1), which discards all entries.
REQ-010 SHALL have per-port lookup ports rd_addr (in, N_READ x REG_ADDRESS_SIZE), dependency (out, N_READ), resolved (out, N_READ), value (out, N_READ x REGISTER_SIZE) and rd_id (out, N_READ x ID_SIZE).

Function
REQ-011 SHALL hold DEPTH entries {valid, done, addr, value} as a circular buffer with head, tail (ID_SIZE bits, wrapping DEPTH-1 -> 0) and count (ID_SIZE+1 bits).
REQ-012 SHALL assert alloc_ready = (count != DEPTH); alloc_valid & alloc_ready writes entry[tail] = {1,0,alloc_addr,0}, tail+1, count+1, with the tag visible on the same cycle.
REQ-013 SHALL ignore alloc_valid when full, including on a cycle that also commits (no pass-through).
REQ-014 SHALL, on wb_valid with entry[wb_id].valid, set done=1 and value=wb_value at the next edge; it SHALL ignore a writeback to an invalid entry; a writeback to an already-done entry SHALL overwrite the value.
REQ-015 SHALL drive commit_ready = entry[head].valid & entry[head].done, with commit_addr/commit_value taken from the head entry; commit_valid & commit_ready clears the entry, head+1, count-1; commit_valid without commit_ready is ignored.
REQ-016 SHALL handle same-cycle alloc and commit with count unchanged and both pointers advancing.
REQ-017 SHALL, per port, search valid entries from tail-1 backward to head, and the youngest entry with addr == rd_addr SHALL win.
REQ-018 SHALL, on a match, drive dependency=1, rd_id=tag, resolved=done, and value=entry value if done else 0; with no match, all outputs SHALL be 0.
REQ-019 SHALL return dependency=0 for rd_addr==0 regardless of entries (r0 hardwired).
REQ-020 SHALL have combinational lookup outputs from the current state; state updates SHALL be visible one cycle after the edge.
REQ-021 SHALL give flush priority over alloc, wb and commit in the same cycle: all valid bits cleared, head=tail=count=0.

Reset
REQ-022 SHALL, on reset, clear all valid/done bits and set head=tail=count=0; alloc_ready=1, commit_ready=0, and all lookup outputs 0 from the first cycle after reset.
REQ-023 SHALL give reset priority over flush and every request; reset mid-operation discards pending entries.

Configuration
REQ-024 SHALL, with DEP_TRACKER_BYPASS_EN defined, forward a same-cycle wb_valid whose wb_id equals a port's matched tag to that port as resolved=1, value=wb_value.
REQ-025 SHALL, without DEP_TRACKER_BYPASS_EN, show writeback results to lookups only from the next cycle.

Structure
REQ-026 SHALL place the entry struct typedef, the DEPTH derivation and tag/address typedefs in shared package dep_pkg.
REQ-027 SHALL implement the per-port youngest-match search as sub-module dep_lookup, instantiated N_READ times.

Verification
REQ-028 SHALL cover: alloc r3 (tag0), alloc r3 (tag1), lookup r3 -> dependency=1, rd_id=1, resolved=0, value=0.
REQ-029 SHALL cover: wb tag1 value 0x22 -> lookup r3 next cycle resolved=1, value=0x22 (BYPASS_EN: same cycle); wb tag0 alone -> r3 still unresolved.
REQ-030 SHALL cover: fill 8 entries -> alloc_ready=0; alloc+commit while full -> alloc refused, count=7.
REQ-031 SHALL cover: wrap-around, committing 5 entries and allocating 5 -> tail=5 (wrapped), youngest match across the wrap is correct.
REQ-032 SHALL cover: flush with simultaneous alloc and wb -> all lookups dependency=0, count=0, alloc_ready=1.
REQ-033 SHALL cover: lookup r0 with r0 allocated -> dependency=0; reset asserted mid-run -> all outputs at reset values next cycle.
